// File: rtl/multdiv_sched_pkg.sv
// Shared constants for the multiply/divide sequencer: FSM state encoding and
// the exception writeback target/codes.
package multdiv_sched_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

    localparam logic [4:0]  RSTATUS_REG = 5'd30;
    localparam logic [31:0] EXC_MULT    = 32'd4;
    localparam logic [31:0] EXC_DIV     = 32'd5;

endpackage

// File: rtl/multdiv_sched_wb_port_mux.sv
// Regfile write-port selection: the MW stage always wins, otherwise the
// multdiv write is forwarded unless it targets r0, in which case it is dropped.
module wb_port_mux (
    input  logic        w_we,
    input  logic [4:0]  w_reg,
    input  logic [31:0] w_data,
    input  logic        md_we,
    input  logic [4:0]  md_reg,
    input  logic [31:0] md_data,
    output logic        ctrl_writeEnable,
    output logic [4:0]  ctrl_writeReg,
    output logic [31:0] data_writeReg
);

    // Priority select between passthrough and multdiv result.
    always_comb begin
        ctrl_writeEnable = 1'b0;
        ctrl_writeReg    = 5'd0;
        data_writeReg    = 32'd0;
        if (w_we) begin
            ctrl_writeEnable = 1'b1;
            ctrl_writeReg    = w_reg;
            data_writeReg    = w_data;
        end else if (md_we && (md_reg != 5'd0)) begin
            ctrl_writeEnable = 1'b1;
            ctrl_writeReg    = md_reg;
            data_writeReg    = md_data;
        end
    end

endmodule

// File: rtl/multdiv_sched.sv
// Sequencer and writeback arbiter for the shared multiply/divide unit.
// Optional macro MD_EXCEPTION_EN: exceptions (unit-reported or watchdog abort)
// redirect the write to rstatus (r30) with code 4 (mult) or 5 (div).
// Without it, exception flags are ignored and an abort writes 0 to rd.
//
// state | meaning
// IDLE  | no op in flight, issue accepted here
// RUN   | op in flight, watchdog counting
// HOLD  | result buffered, waiting for a free write port
module multdiv_sched
    import multdiv_sched_pkg::*;
#(
    parameter int TIMEOUT = 40,
    parameter int CW      = 6     // 2**CW must exceed TIMEOUT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        issue_mult,
    input  logic        issue_div,
    input  logic [4:0]  issue_rd,
    input  logic        md_ready,
    input  logic        md_exception,
    input  logic [31:0] md_result,
    input  logic        w_we,
    input  logic [4:0]  w_reg,
    input  logic [31:0] w_data,
    output logic        md_start_mult,
    output logic        md_start_div,
    output logic        stall,
    output logic        busy,
    output logic        ctrl_writeEnable,
    output logic [4:0]  ctrl_writeReg,
    output logic [31:0] data_writeReg
);

    logic [1:0]    state;
    logic          op_is_div;
    logic [4:0]    rd_q;
    logic [31:0]   res_q;
    logic [CW-1:0] wd_cnt;
    logic          md_done;
    logic [31:0]   data_sel;
    logic [4:0]    md_reg;
    logic [31:0]   md_data;

    // Every combinational output is forced low while reset is held.
    assign md_start_mult = reset && (state == IDLE) && issue_mult;
    assign md_start_div  = reset && (state == IDLE) && issue_div && !issue_mult;
    assign md_done       = reset && !w_we &&
                           (((state == RUN) && md_ready) || (state == HOLD));
    assign stall         = reset && !md_done &&
                           ((state != IDLE) || issue_mult || issue_div);
    assign busy          = reset && (state != IDLE);
    assign data_sel      = (state == RUN) ? md_result : res_q;

`ifdef MD_EXCEPTION_EN
    logic exc_q;
    logic exc_now;

    assign exc_now = (state == RUN) ? md_exception : exc_q;
    assign md_reg  = exc_now ? RSTATUS_REG : rd_q;
    assign md_data = exc_now ? (op_is_div ? EXC_DIV : EXC_MULT) : data_sel;

    // Exception flag follows the result into HOLD; an abort forces it.
    always_ff @(posedge clock) begin
        if (!reset) begin
            exc_q <= 1'b0;
        end else if (state == RUN) begin
            if (md_ready)
                exc_q <= md_exception;
            else if (wd_cnt == CW'(TIMEOUT - 1))
                exc_q <= 1'b1;
        end
    end
`else
    logic unused_exc;

    assign unused_exc = md_exception;
    assign md_reg     = rd_q;
    assign md_data    = data_sel;
`endif

    // Sequencing FSM with watchdog; an abort parks a zero result in HOLD.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= IDLE;
            op_is_div <= 1'b0;
            rd_q      <= 5'd0;
            res_q     <= 32'd0;
            wd_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (issue_mult || issue_div) begin
                        rd_q      <= issue_rd;
                        op_is_div <= !issue_mult;
                        wd_cnt    <= '0;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    wd_cnt <= wd_cnt + CW'(1);
                    if (md_ready) begin
                        if (w_we) begin
                            res_q <= md_result;
                            state <= HOLD;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (wd_cnt == CW'(TIMEOUT - 1)) begin
                        res_q <= 32'd0;
                        state <= HOLD;
                    end
                end
                HOLD: begin
                    if (!w_we)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    wb_port_mux u_wb_port_mux (
        .w_we             (w_we),
        .w_reg            (w_reg),
        .w_data           (w_data),
        .md_we            (md_done),
        .md_reg           (md_reg),
        .md_data          (md_data),
        .ctrl_writeEnable (ctrl_writeEnable),
        .ctrl_writeReg    (ctrl_writeReg),
        .data_writeReg    (data_writeReg)
    );

endmodule

// File: tb/tb_multdiv_sched.sv
// Bench for multdiv_sched: table vectors for issue/reset behaviour plus
// hand-written multi-cycle sequences; regfile writes go through a scoreboard.
module tb_multdiv_sched;

    logic        clock = 1'b0;
    logic        reset;
    logic        issue_mult, issue_div;
    logic [4:0]  issue_rd;
    logic        md_ready, md_exception;
    logic [31:0] md_result;
    logic        w_we;
    logic [4:0]  w_reg;
    logic [31:0] w_data;
    logic        md_start_mult, md_start_div, stall, busy;
    logic        ctrl_writeEnable;
    logic [4:0]  ctrl_writeReg;
    logic [31:0] data_writeReg;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct packed {
        logic [4:0]  r;
        logic [31:0] d;
    } wr_t;
    wr_t exp_q[$];

    typedef struct {
        logic        rst;
        logic        im;
        logic        id;
        logic [4:0]  rd;
        logic        we;
        logic [4:0]  wr;
        logic [31:0] wd;
        logic        sm;
        logic        sd;
        logic        st;
        logic        bz;
    } vec_t;
    vec_t vt[8];

    always #5 clock = ~clock;

    multdiv_sched dut (
        .clock            (clock),
        .reset            (reset),
        .issue_mult       (issue_mult),
        .issue_div        (issue_div),
        .issue_rd         (issue_rd),
        .md_ready         (md_ready),
        .md_exception     (md_exception),
        .md_result        (md_result),
        .w_we             (w_we),
        .w_reg            (w_reg),
        .w_data           (w_data),
        .md_start_mult    (md_start_mult),
        .md_start_div     (md_start_div),
        .stall            (stall),
        .busy             (busy),
        .ctrl_writeEnable (ctrl_writeEnable),
        .ctrl_writeReg    (ctrl_writeReg),
        .data_writeReg    (data_writeReg)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic clr();
        issue_mult = 0; issue_div = 0; issue_rd = 0;
        md_ready = 0; md_exception = 0; md_result = 0;
        w_we = 0; w_reg = 0; w_data = 0;
    endtask

    task automatic set_w(input logic we, input logic [4:0] r, input logic [31:0] d);
        w_we = we; w_reg = r; w_data = d;
        if (we) exp_q.push_back({r, d});
    endtask

    task automatic next();
        @(posedge clock);
        #1;
    endtask

    // Every regfile write is matched against the next expected write.
    always @(negedge clock) begin
        if (ctrl_writeEnable === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_write: got r%0d=%h expected no write",
                         ctrl_writeReg, data_writeReg);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("write_reg", {27'd0, ctrl_writeReg}, {27'd0, e.r});
                chk("write_data", data_writeReg, e.d);
            end
        end
    end

    initial begin
        int stall_cnt;
        int start_cnt;
        logic [4:0]  exc_r;
        logic [31:0] exc_d;

        //          rst im id rd we wr  wd          sm sd st bz
        vt[0] = '{1'b0, 1, 1, 5'd3, 0, 5'd0, 32'h0,     0, 0, 0, 0};
        vt[1] = '{1'b0, 0, 0, 5'd0, 1, 5'd4, 32'h11,    0, 0, 0, 0};
        vt[2] = '{1'b1, 1, 0, 5'd2, 0, 5'd0, 32'h0,     1, 0, 1, 0};
        vt[3] = '{1'b1, 0, 1, 5'd2, 0, 5'd0, 32'h0,     0, 1, 1, 0};
        vt[4] = '{1'b1, 1, 1, 5'd2, 0, 5'd0, 32'h0,     1, 0, 1, 0};
        vt[5] = '{1'b1, 0, 0, 5'd0, 0, 5'd0, 32'h0,     0, 0, 0, 0};
        vt[6] = '{1'b1, 0, 0, 5'd0, 1, 5'd9, 32'hdead,  0, 0, 0, 0};
        vt[7] = '{1'b1, 1, 0, 5'd6, 1, 5'd2, 32'h3,     1, 0, 1, 0};

        clr();
        reset = 0;
        next();
        @(negedge clock);
        chk("rst_stall", {31'd0, stall}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_we", {31'd0, ctrl_writeEnable}, 0);
        chk("rst_reg", {27'd0, ctrl_writeReg}, 0);
        chk("rst_data", data_writeReg, 0);
        next();

        // Table: each vector from IDLE, then one reset cycle to return there.
        for (int i = 0; i < 8; i++) begin
            clr();
            reset = vt[i].rst;
            issue_mult = vt[i].im; issue_div = vt[i].id; issue_rd = vt[i].rd;
            set_w(vt[i].we, vt[i].wr, vt[i].wd);
            @(negedge clock);
            chk($sformatf("v%0d_start_mult", i), {31'd0, md_start_mult}, {31'd0, vt[i].sm});
            chk($sformatf("v%0d_start_div", i), {31'd0, md_start_div}, {31'd0, vt[i].sd});
            chk($sformatf("v%0d_stall", i), {31'd0, stall}, {31'd0, vt[i].st});
            chk($sformatf("v%0d_busy", i), {31'd0, busy}, {31'd0, vt[i].bz});
            next();
            clr();
            reset = 0;
            @(negedge clock);
            chk($sformatf("v%0d_rst_busy", i), {31'd0, busy}, 0);
            chk($sformatf("v%0d_rst_stall", i), {31'd0, stall}, 0);
            next();
        end
        reset = 1;
        next();

        // Port free: mult to r5, 33 waiting cycles, then ready with w_we=0.
        issue_mult = 1; issue_rd = 5;
        @(negedge clock);
        start_cnt = (md_start_mult === 1'b1) ? 1 : 0;
        next();
        clr();
        stall_cnt = 0;
        for (int k = 0; k < 33; k++) begin
            @(negedge clock);
            if (stall === 1'b1) stall_cnt++;
            if (md_start_mult === 1'b1 || md_start_div === 1'b1) start_cnt++;
            next();
        end
        chk("free_stall_cycles", stall_cnt, 33);
        chk("free_start_pulses", start_cnt, 1);
        md_ready = 1; md_result = 32'h54;
        exp_q.push_back({5'd5, 32'h54});
        @(negedge clock);
        chk("free_stall_at_write", {31'd0, stall}, 0);
        chk("free_busy_at_write", {31'd0, busy}, 1);
        next();
        clr();
        @(negedge clock);
        chk("free_busy_after", {31'd0, busy}, 0);
        next();

        // Port busy: div to r7, ready with MW writing r3 for two cycles.
        issue_div = 1; issue_rd = 7;
        next();
        clr();
        repeat (5) next();
        md_ready = 1; md_result = 32'h1234;
        set_w(1, 5'd3, 32'd9);
        @(negedge clock);
        chk("busy_stall_ready", {31'd0, stall}, 1);
        next();
        md_ready = 0; md_result = 0;
        set_w(1, 5'd3, 32'd9);
        @(negedge clock);
        chk("hold_busy", {31'd0, busy}, 1);
        chk("hold_stall", {31'd0, stall}, 1);
        next();
        set_w(0, 5'd0, 32'd0);
        exp_q.push_back({5'd7, 32'h1234});
        @(negedge clock);
        chk("hold_stall_at_write", {31'd0, stall}, 0);
        next();
        @(negedge clock);
        chk("hold_busy_after", {31'd0, busy}, 0);
        next();

        // Exception on a div, port free.
        issue_div = 1; issue_rd = 8;
        next();
        clr();
        repeat (3) next();
        md_ready = 1; md_exception = 1; md_result = 32'h77;
`ifdef MD_EXCEPTION_EN
        exp_q.push_back({5'd30, 32'd5});
`else
        exp_q.push_back({5'd8, 32'h77});
`endif
        next();
        clr();
        @(negedge clock);
        chk("exc_div_busy_after", {31'd0, busy}, 0);
        next();

        // Exception on a mult, buffered through HOLD.
        issue_mult = 1; issue_rd = 9;
        next();
        clr();
        repeat (2) next();
        md_ready = 1; md_exception = 1; md_result = 32'h99;
        set_w(1, 5'd1, 32'd2);
        next();
        clr();
`ifdef MD_EXCEPTION_EN
        exp_q.push_back({5'd30, 32'd4});
`else
        exp_q.push_back({5'd9, 32'h99});
`endif
        next();
        @(negedge clock);
        chk("exc_mult_busy_after", {31'd0, busy}, 0);
        next();

        // Watchdog: mult to r10, md_ready never comes.
        issue_mult = 1; issue_rd = 10;
        next();
        clr();
        stall_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            if (stall === 1'b1) stall_cnt++;
            next();
        end
        chk("wd_stall_cycles", stall_cnt, 40);
`ifdef MD_EXCEPTION_EN
        exc_r = 5'd30; exc_d = 32'd4;
`else
        exc_r = 5'd10; exc_d = 32'd0;
`endif
        exp_q.push_back({exc_r, exc_d});
        @(negedge clock);
        chk("wd_busy_hold", {31'd0, busy}, 1);
        chk("wd_stall_at_write", {31'd0, stall}, 0);
        next();
        @(negedge clock);
        chk("wd_busy_after", {31'd0, busy}, 0);
        next();

        // rd=0: result dropped, FSM still returns to IDLE.
        issue_mult = 1; issue_rd = 0;
        next();
        clr();
        repeat (2) next();
        md_ready = 1; md_result = 32'hff;
        @(negedge clock);
        chk("rd0_we", {31'd0, ctrl_writeEnable}, 0);
        next();
        clr();
        @(negedge clock);
        chk("rd0_busy_after", {31'd0, busy}, 0);
        next();

        // Reset mid-RUN, then a stale md_ready in IDLE.
        issue_mult = 1; issue_rd = 12;
        next();
        clr();
        repeat (3) next();
        reset = 0;
        @(negedge clock);
        chk("midrun_rst_busy", {31'd0, busy}, 0);
        chk("midrun_rst_stall", {31'd0, stall}, 0);
        chk("midrun_rst_we", {31'd0, ctrl_writeEnable}, 0);
        next();
        reset = 1;
        md_ready = 1; md_result = 32'hbeef;
        @(negedge clock);
        chk("stale_we", {31'd0, ctrl_writeEnable}, 0);
        chk("stale_reg", {27'd0, ctrl_writeReg}, 0);
        chk("stale_data", data_writeReg, 0);
        chk("stale_busy", {31'd0, busy}, 0);
        chk("stale_stall", {31'd0, stall}, 0);
        next();
        clr();

        // Reset while in HOLD discards the buffered result.
        issue_div = 1; issue_rd = 11;
        next();
        clr();
        md_ready = 1; md_result = 32'h42;
        set_w(1, 5'd4, 32'd6);
        next();
        clr();
        reset = 0;
        @(negedge clock);
        chk("holdrst_we", {31'd0, ctrl_writeEnable}, 0);
        next();
        reset = 1;
        @(negedge clock);
        chk("holdrst_busy_after", {31'd0, busy}, 0);
        next();

        repeat (3) next();
        chk("pending_writes", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/multdiv_sched.md
# multdiv_sched

Sequencer and writeback arbiter for the shared multiply/divide unit in the 5-stage pipeline.
- Accepts mult/div issue requests from the X stage and pulses the unit's start inputs.
- Tracks the operation in flight and asserts the pipeline stall until the operation completes.
- Arbitrates the single regfile write port between the MW stage and the multdiv result; MW has priority and the result is buffered when the port is busy.
- Enforces a watchdog on operation length.

## Interface
- TIMEOUT, 40: RUN cycles allowed before the operation is aborted.
- CW, 6: watchdog counter width; must satisfy 2^CW > TIMEOUT.
- clock  in  1  master clock; all state updates on rising edge
- reset  in  1  one clock; reset is synchronous and active-low
- issue_mult  in  1  X stage holds a mult
- issue_div  in  1  X stage holds a div
- issue_rd  in  5  destination register of the issuing op
- md_ready  in  1  multdiv data_resultRDY
- md_exception  in  1  multdiv data_exception
- md_result  in  32  multdiv data_result
- w_we  in  1  MW stage regfile write enable
- w_reg  in  5  MW stage destination
- w_data  in  32  MW stage write data
- md_start_mult  out  1  ctrl_MULT pulse to multdiv
- md_start_div  out  1  ctrl_DIV pulse to multdiv
- stall  out  1  freeze PC/FD, insert nop into DX
- busy  out  1  state != IDLE
- ctrl_writeEnable  out  1  regfile write enable
- ctrl_writeReg  out  5  regfile destination
- data_writeReg  out  32  regfile write data

## Operation
- States: IDLE, RUN, HOLD.
- Registered state: state, op_is_div, rd_q[4:0], res_q[31:0], exc_q, wd_cnt[CW-1:0].
- Issue rules:
  - Issue is accepted only in IDLE.
  - Accepting an issue drives md_start_mult/md_start_div combinationally in the same cycle (exactly one cycle high) and latches issue_rd and op_is_div. Next state is RUN.
  - If issue_mult and issue_div are both high, mult wins.
  - Issue outside IDLE is ignored; the stall upstream makes this unreachable.
- RUN:
  - wd_cnt increments each cycle.
  - On md_ready with w_we=0: write the result this cycle, go to IDLE.
  - On md_ready with w_we=1: capture md_result and md_exception into res_q/exc_q, go to HOLD.
  - On wd_cnt==TIMEOUT-1 with no md_ready: abort. Set exc_q=1, go to HOLD.
- HOLD: when w_we=0, write res_q, go to IDLE. Otherwise remain in HOLD.
- Write port:
  - w_we=1 passes w_reg/w_data through unchanged.
  - A multdiv write drives ctrl_writeEnable=1, ctrl_writeReg=rd_q, data_writeReg=result.
  - A result whose rd_q==0 is dropped, with no write. The FSM still returns to IDLE.
- stall = (state != IDLE) | issue_mult | issue_div, with one exception: stall is deasserted in the cycle the result is written.
- md_ready seen in IDLE is ignored. It is stale, because multdiv is not reset by this block.
- On reset=0 at any point, including mid-RUN or in HOLD:
  - state=IDLE, all registers cleared.
  - Every output is 0 except the w_* passthrough.
  - Any in-flight result is discarded.

## Timing
- Issue at cycle t: start pulse at t, RUN from t+1.
- md_ready at t with the port free: write at t, IDLE at t+1, stall low at t.
- md_ready at t with the port busy: HOLD from t+1; write in the first subsequent cycle with w_we=0.
- Watchdog: abort after exactly TIMEOUT cycles in RUN; the write is no earlier than cycle t+TIMEOUT+1.
- A single cycle never carries two writes. The w_* passthrough always has priority.
- Reset values: all outputs 0; state IDLE; wd_cnt 0.

## Configuration
MD_EXCEPTION_EN sets how exceptions (exc_q=1 or md_exception=1) are written back.

With MD_EXCEPTION_EN defined, an exception redirects the write:
- ctrl_writeReg=30 (rstatus).
- data_writeReg=4 for a mult, 5 for a div.

Without MD_EXCEPTION_EN:
- Exception flags are ignored. md_result (or res_q) is written to rd_q.
- A watchdog abort writes 0 to rd_q.
- The exc_q register is removed.

## Structure
- Shared package:
  - State encoding localparams: IDLE=2'd0, RUN=2'd1, HOLD=2'd2.
  - RSTATUS_REG=5'd30, EXC_MULT=32'd4, EXC_DIV=32'd5.
- One natural sub-module: wb_port_mux. It is the combinational selection between the w_* passthrough and the multdiv write, including the rd==0 drop.
- Kept in the top level: FSM and watchdog.

## Test plan
- Port free: reset, issue_mult with issue_rd=5, md_ready after 33 cycles with md_result=0x00000054 and w_we=0 -> single write r5=0x54 that cycle; stall high for exactly 33 cycles after the issue cycle; busy low next cycle.
- Port busy at completion: issue_div with rd=7, md_ready coincident with w_we=1 (w_reg=3, w_data=9) for 2 cycles -> r3=9 is written, then r7=result on the third cycle from HOLD.
- Exception: with MD_EXCEPTION_EN, div with md_exception=1 -> r30=5 and no write to rd. Without the macro, rd=md_result.
- Watchdog: issue_mult with md_ready never asserted -> abort after 40 RUN cycles; r30=4 written with the macro, or rd=0 without it; FSM returns to IDLE.
- Boundaries:
  - issue_rd=0 -> no write, FSM returns to IDLE.
  - issue_mult and issue_div together -> only md_start_mult pulses.
  - reset=0 mid-RUN, followed by a stale md_ready -> no write, outputs 0.
